// File: rtl/seg_scan_ctrl_if.sv
// Host digit-write handshake plus the single display-memory port.
// Latency: n/a (signal bundle only).
// Backpressure: wr_req is held by the host until wr_ack pulses.
interface seg_scan_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 6
);
  // host write channel
  logic             wr_req;
  logic [DEPTH-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ack;
  // display memory port (controller owns address/write side)
  logic [DEPTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_data_in;
  logic             mem_rd_wr_en;
  logic [WIDTH-1:0] mem_data_out;

  // controller side
  modport master (
    input  wr_req, wr_addr, wr_data, mem_data_out,
    output wr_ack, mem_addr, mem_data_in, mem_rd_wr_en
  );

  // host + memory side
  modport slave (
    output wr_req, wr_addr, wr_data, mem_data_out,
    input  wr_ack, mem_addr, mem_data_in, mem_rd_wr_en
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment refresh controller sharing one memory port with host writes.
// Latency: tick -> new anode 3 cycles; wr_req -> wr_ack 1 cycle in SHOW, 4 cycles worst case.
// Backpressure: host writes are stalled (wr_req held, no ack) during the tick, BLANK and FETCH cycles.
module seg_scan_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 6,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BASE_ADDR   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_scan_ctrl_if.master       bus,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            tick;
  logic [DW-1:0]   digit;

  // Only bits [7] (blank), [4] (dp) and [3:0] (hex) carry meaning.
  logic unused_bits;
  assign unused_bits = ^bus.mem_data_out;

  assign tick = (cnt == CW'(REFRESH_DIV - 1));

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      4'hB:    return 7'h03;
      4'hC:    return 7'h46;
      4'hD:    return 7'h21;
      4'hE:    return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // Free-running digit-slot prescaler; keeps counting in every state.
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Scan FSM: blank anodes, fetch the digit code, then show it while serving host writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= BLANK;
      digit            <= '0;
      an               <= '1;
      seg              <= 7'h7F;
      dp               <= 1'b1;
      bus.wr_ack       <= 1'b0;
      bus.mem_rd_wr_en <= 1'b0;
      bus.mem_addr     <= DEPTH'(BASE_ADDR);
      bus.mem_data_in  <= '0;
    end else begin
      // write enable and ack are single-cycle pulses
      bus.wr_ack       <= 1'b0;
      bus.mem_rd_wr_en <= 1'b0;
      case (state)
        BLANK: begin
          an           <= '1;
          bus.mem_addr <= DEPTH'(BASE_ADDR) + DEPTH'(digit);
          state        <= FETCH;
        end
        FETCH: begin
          an <= ~(NUM_DIGITS'(1) << digit);
          if (bus.mem_data_out[7]) begin
            seg <= 7'h7F;
            dp  <= 1'b1;
          end else begin
            seg <= hex_to_seg(bus.mem_data_out[3:0]);
            dp  <= ~bus.mem_data_out[4];
          end
          state <= SHOW;
        end
        SHOW: begin
          if (tick) begin
            // a write pulse issued last cycle still completes at this edge
            digit <= (digit == DW'(NUM_DIGITS - 1)) ? '0 : digit + 1'b1;
            state <= BLANK;
          end else if (bus.wr_req && !bus.wr_ack && !bus.mem_rd_wr_en) begin
            bus.mem_addr     <= bus.wr_addr;
            bus.mem_data_in  <= bus.wr_data;
            bus.mem_rd_wr_en <= 1'b1;
            bus.wr_ack       <= 1'b1;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: random host writes against a phase-arithmetic display model.
// Latency: n/a.
// Backpressure: host holds wr_req until it sees wr_ack, then drops it.
module tb_seg_scan_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 6;
  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int BASE2 = 62;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  seg_scan_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus2 ();

  logic [ND-1:0] an, an2;
  logic [6:0]    seg, seg2;
  logic          dp, dp2;

  seg_scan_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .an(an), .seg(seg), .dp(dp)
  );

  seg_scan_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BASE_ADDR(BASE2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .an(an2), .seg(seg2), .dp(dp2)
  );

  // display memory emulation and the model's view of what it should hold
  logic [WIDTH-1:0] pmem    [64];
  logic [WIDTH-1:0] ref_mem [64];
  logic             load;

  // memory: preload from the model, otherwise take DUT writes
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 64; i++) pmem[i] <= ref_mem[i];
    end else if (bus.mem_rd_wr_en) begin
      pmem[bus.mem_addr] <= bus.mem_data_in;
    end
  end
  assign bus.mem_data_out  = pmem[bus.mem_addr];
  assign bus2.mem_data_out = 8'h00;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // model state
  int          e;              // rising edges since the last reset edge
  logic [7:0]  shown;          // code the DUT should have fetched for the current slot
  bit          wr_active;
  int          ack_e;
  logic [5:0]  cur_addr;
  logic [7:0]  cur_data;
  bit          writes_on;
  bit          collide_pending;
  logic [13:0] dq [$];

  task automatic run_cycles(input int n);
    int p, s, d, x;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    bit         just_done;
    logic [13:0] t;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      p = e % DIV;
      s = e / DIV;
      just_done = 0;
      // display model: phase 0 = BLANK state, 1 = blanking visible, >=2 digit shown
      if (p == 1) begin
        shown = ref_mem[s % ND];
        check("an_blank", an, 4'hF);
        check("fetch_addr", bus.mem_addr, (s % ND) % 64);
        check("fetch_addr_wrap", bus2.mem_addr, (BASE2 + s % ND) % 64);
        check("an2_blank", an2, 4'hF);
      end else if (e >= 2) begin
        d  = (p == 0) ? (s - 1) % ND : s % ND;
        ea = ~(4'b0001 << d);
        es = shown[7] ? 7'h7F : dec_tab[shown[3:0]];
        ed = shown[7] ? 1'b1 : ~shown[4];
        check("an", an, ea);
        check("seg", seg, es);
        check("dp", dp, ed);
        check("an2", an2, ea);
      end
      // host write channel
      if (wr_active && e == ack_e) begin
        check("wr_ack", bus.wr_ack, 1);
        check("wr_en", bus.mem_rd_wr_en, 1);
        check("wr_addr", bus.mem_addr, cur_addr);
        check("wr_data", bus.mem_data_in, cur_data);
        ref_mem[cur_addr] = cur_data;
        wr_active   = 0;
        bus.wr_req  = 1'b0;
        just_done   = 1;
      end else begin
        check("wr_ack_idle", bus.wr_ack, 0);
        check("wr_en_idle", bus.mem_rd_wr_en, 0);
      end
      if (writes_on && !wr_active && !just_done &&
          (collide_pending ? (p == DIV - 1) : ($urandom_range(0, 3) == 0))) begin
        collide_pending = 0;
        if (dq.size() > 0) begin
          t = dq.pop_front();
          cur_addr = t[13:8];
          cur_data = t[7:0];
        end else begin
          cur_addr = 6'($urandom_range(0, 7));
          cur_data = 8'($urandom_range(0, 255));
        end
        bus.wr_req  = 1'b1;
        bus.wr_addr = cur_addr;
        bus.wr_data = cur_data;
        // accepted in the first SHOW cycle that is not the tick cycle
        x = e;
        while (!((x % DIV) >= 2 && (x % DIV) <= DIV - 2)) x++;
        ack_e     = x + 1;
        wr_active = 1;
      end
    end
  endtask

  initial begin
    bus.wr_req   = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus2.wr_req  = 1'b0;
    bus2.wr_addr = '0;
    bus2.wr_data = '0;
    e = 0;
    shown = 8'h00;
    wr_active = 0;
    ack_e = 0;
    cur_addr = '0;
    cur_data = '0;
    writes_on = 0;
    collide_pending = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom_range(0, 255));
    ref_mem[0] = 8'h01;
    ref_mem[1] = 8'h02;
    ref_mem[2] = 8'h03;
    ref_mem[3] = 8'h04;
    load = 1'b1;
    rst  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1);
    check("rst_ack", bus.wr_ack, 0);
    check("rst_wr_en", bus.mem_rd_wr_en, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_data_in, 0);
    check("rst_addr2", bus2.mem_addr, BASE2);
    check("rst_seg2", seg2, 7'h7F);
    check("rst_dp2", dp2, 1);

    // plain scan of the preloaded digits, two full rounds
    rst = 1'b0;
    e = 0;
    run_cycles(2 * ND * DIV + 4);

    // host writes: first one collides with a tick, then blank/dp codes, then random
    dq.push_back({6'd0, 8'h0F});
    dq.push_back({6'd1, 8'h80});
    dq.push_back({6'd2, 8'h1A});
    writes_on = 1;
    collide_pending = 1;
    run_cycles(700);
    writes_on = 0;
    run_cycles(8);

    // reset arriving together with a host request in SHOW
    for (int k = 0; k < 2 * DIV && (e % DIV) != 3; k++) run_cycles(1);
    check("pre_rst_phase", e % DIV, 3);
    bus.wr_req  = 1'b1;
    bus.wr_addr = 6'd0;
    bus.wr_data = ~ref_mem[0];
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_seg", seg, 7'h7F);
    check("mid_rst_dp", dp, 1);
    check("mid_rst_wr_en", bus.mem_rd_wr_en, 0);
    check("mid_rst_ack", bus.wr_ack, 0);
    check("mid_rst_addr", bus.mem_addr, 0);
    check("mid_rst_wdata", bus.mem_data_in, 0);
    rst = 1'b0;
    bus.wr_req = 1'b0;
    e = 0;
    run_cycles(1);
    check("mid_rst_no_write", pmem[0], ref_mem[0]);
    writes_on = 1;
    run_cycles(200);
    writes_on = 0;
    run_cycles(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
